transaction_draw_scheduler: RTL and testbench

Upstream sequencer for the transaction drawing chain. It accepts transaction-draw requests through a small FIFO and maps each slot index to a screen origin. It then restarts the seven-stage transaction drawer, holds its enable until the drawer reports completion, and drives the colour and plot strobe that go to the VGA adapter with the drawer's coordinates. It serialises requests, so only one transaction graphic is drawn at a time.

---
 rtl/visual_pkg.sv | 31 +++
 rtl/transaction_draw_scheduler_if.sv | 19 +
 rtl/req_fifo.sv | 46 ++++
 rtl/transaction_draw_scheduler.sv | 137 +++++++++++++
 tb/tb_transaction_draw_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/visual_pkg.sv
// Shared constants, request record and sequencer state encoding for the
// transaction drawing chain.
package visual_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    DRAW,
    FINISH
  } sched_state_t;

  typedef struct packed {
    logic [2:0] slot;
    logic [2:0] colour;
    logic       erase;
  } draw_req_t;

  // Row origin wraps at 8 bits, matching the drawer's y register width.
  function automatic logic [7:0] slot_origin_y(input int y0, input int pitch,
                                               input logic [2:0] slot);
    int y;
    y = y0 + int'(slot) * pitch;
    return 8'(y);
  endfunction

endpackage

// File: rtl/transaction_draw_scheduler_if.sv
// Request channel into the transaction draw scheduler.
interface transaction_draw_scheduler_if;

  // Handshake: a request transfers on every clock edge where req_valid and
  // req_ready are both high; the master holds slot/colour/erase stable while
  // req_valid is high, and req_ready never depends on req_valid.
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_slot;
  logic [2:0] req_colour;
  logic       req_erase;

  modport master (output req_valid, req_slot, req_colour, req_erase,
                  input  req_ready);

  modport slave  (input  req_valid, req_slot, req_colour, req_erase,
                  output req_ready);

endinterface

// File: rtl/req_fifo.sv
// Synchronous FIFO with full/empty flags; rd_data shows the head entry.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A pop frees the head slot, so a write alongside it is legal even when full.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/transaction_draw_scheduler.sv
// Serialises transaction-draw requests: maps slot to origin, restarts the
// drawer, gates its enable/plot until done, and guards it with a watchdog.
module transaction_draw_scheduler
  import visual_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int X_ORIGIN   = 16,
  parameter int Y_ORIGIN   = 24,
  parameter int ROW_PITCH  = 40,
  parameter int SLOTS      = 5,
  parameter int WATCHDOG   = 4096
) (
  input  logic                             clk,
  input  logic                             reset,
  transaction_draw_scheduler_if.slave      req,
  output logic                             draw_resetn,
  output logic                             draw_enable,
  input  logic                             draw_done,
  output logic [8:0]                       start_x,
  output logic [7:0]                       start_y,
  output logic [2:0]                       colour,
  output logic                             plot,
  output logic                             busy,
  output logic                             job_done,
  output logic                             error,
  output sched_state_t                     dbg_state
);

  localparam int WD_W = $clog2(WATCHDOG);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG - 1);

  sched_state_t    state;
  sched_state_t    state_next;
  draw_req_t       head;
  draw_req_t       job;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            slot_ok;
  logic            load_bad;
  logic            timeout;
  logic            finish_ok;
  logic [WD_W-1:0] wd_cnt;

  assign req.req_ready = !fifo_full;
  assign push          = req.req_valid && req.req_ready;

  req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(draw_req_t))
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({req.req_slot, req.req_colour, req.req_erase}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign slot_ok   = int'(job.slot) < SLOTS;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_bad   = 1'b0;
    timeout    = 1'b0;
    finish_ok  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (slot_ok) begin
          state_next = CLEAR;
        end else begin
          load_bad   = 1'b1;
          state_next = IDLE;
        end
      end
      CLEAR: state_next = DRAW;
      DRAW: begin
        if (draw_done) begin
          finish_ok  = 1'b1;
          state_next = FINISH;
        end else if (wd_cnt == WD_LAST) begin
          timeout    = 1'b1;
          state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drawer controls are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      job         <= '0;
      wd_cnt      <= '0;
      draw_resetn <= 1'b1;
      draw_enable <= 1'b0;
      plot        <= 1'b0;
      job_done    <= 1'b0;
      error       <= 1'b0;
      start_x     <= 9'(X_ORIGIN);
      start_y     <= 8'(Y_ORIGIN);
      colour      <= COLOUR_BLACK;
    end else begin
      if (pop) job <= head;
      wd_cnt      <= (state == DRAW) ? wd_cnt + WD_W'(1) : '0;
      draw_resetn <= (state_next != CLEAR);
      draw_enable <= (state_next == DRAW);
      plot        <= (state_next == DRAW);
      job_done    <= finish_ok;
      if (load_bad || timeout) error <= 1'b1;
      if (state == LOAD && slot_ok) begin
        start_x <= 9'(X_ORIGIN);
        start_y <= slot_origin_y(Y_ORIGIN, ROW_PITCH, job.slot);
        colour  <= job.erase ? COLOUR_BLACK : job.colour;
      end
    end
  end

endmodule

// File: tb/tb_transaction_draw_scheduler.sv
// Self-checking bench for transaction_draw_scheduler: request driver, drawer
// model, scoreboard fed at acceptance and drained by an output monitor.
module tb_transaction_draw_scheduler;
  import visual_pkg::*;

  localparam int X_ORIGIN  = 16;
  localparam int Y_ORIGIN  = 24;
  localparam int ROW_PITCH = 40;
  localparam int SLOTS     = 5;
  localparam int WATCHDOG  = 4096;
  localparam int FULL_LEN  = 3328;
  localparam int BUDGET    = 20000;
  // Expected job record: {plot_len[12:0], error_after, timed_out, start_x[8:0], start_y[7:0], colour[2:0]}
  localparam int W = 35;

  logic         clk = 1'b0;
  logic         reset;
  logic         draw_resetn, draw_enable, draw_done, plot, busy, job_done, error;
  logic [8:0]   start_x;
  logic [7:0]   start_y;
  logic [2:0]   colour;
  sched_state_t dbg_state;

  transaction_draw_scheduler_if rq ();

  transaction_draw_scheduler #(
    .FIFO_DEPTH (4),
    .X_ORIGIN   (X_ORIGIN),
    .Y_ORIGIN   (Y_ORIGIN),
    .ROW_PITCH  (ROW_PITCH),
    .SLOTS      (SLOTS),
    .WATCHDOG   (WATCHDOG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (rq),
    .draw_resetn (draw_resetn),
    .draw_enable (draw_enable),
    .draw_done   (draw_done),
    .start_x     (start_x),
    .start_y     (start_y),
    .colour      (colour),
    .plot        (plot),
    .busy        (busy),
    .job_done    (job_done),
    .error       (error),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / global time limit ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int  len_q[$];
  bit  err_acc        = 1'b0;
  int  exp_done_total = 0;
  int  done_seen      = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_eq(input string name, input longint act, input longint exp);
    check(act == exp, name, act, exp);
  endtask

  // Reference model: what each accepted request must produce.
  task automatic model_accept(input int slot, input int col, input bit erase, input int len);
    bit tmo;
    int sy;
    if (slot >= SLOTS) begin
      err_acc = 1'b1;
    end else begin
      tmo = (len == 0);
      if (tmo) err_acc = 1'b1;
      else     exp_done_total++;
      sy = (Y_ORIGIN + slot * ROW_PITCH) % 256;
      exp_q.push_back({13'(tmo ? WATCHDOG : len), err_acc, tmo, 9'(X_ORIGIN), 8'(sy),
                       3'(erase ? 0 : col)});
      len_q.push_back(len);
    end
  endtask

  // ---------------- drawer model ----------------
  // len 0 means the drawer never reports completion.
  int drw_cnt = 0;
  int drw_len = 0;
  always @(posedge clk) begin
    if (!draw_resetn) begin
      drw_cnt <= 0;
      if (len_q.size() != 0) drw_len <= len_q.pop_front();
      else                   drw_len <= 0;
    end else if (draw_enable) begin
      drw_cnt <= drw_cnt + 1;
    end
  end
  assign draw_done = (drw_len != 0) && (drw_cnt >= drw_len - 1);

  // ---------------- driver tasks ----------------
  task automatic push_req(input int slot, input int col, input bit erase, input int len);
    int waited = 0;
    @(negedge clk);
    rq.req_valid  = 1'b1;
    rq.req_slot   = 3'(slot);
    rq.req_colour = 3'(col);
    rq.req_erase  = erase;
    while (!rq.req_ready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!rq.req_ready) begin
      check_eq("push_ready_timeout", rq.req_ready, 1);
      rq.req_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(slot, col, erase, len);
      #1 rq.req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int idle_run = 0;
    int cyc = 0;
    while ((idle_run < 3 || exp_q.size() != 0) && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (busy) idle_run = 0;
      else      idle_run++;
    end
    check(idle_run >= 3 && exp_q.size() == 0, {name, "_drain"}, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] cur;
  int clr_run;
  int plot_run;
  initial begin
    cur = '0;
    clr_run = 0;
    plot_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        clr_run  = 0;
        plot_run = 0;
      end else begin
        if (!draw_resetn) begin
          clr_run++;
          if (clr_run == 1) begin
            check(exp_q.size() != 0, "clear_without_job", exp_q.size(), 1);
            if (exp_q.size() != 0) begin
              cur = exp_q.pop_front();
              check_eq("clear_start_x", start_x, cur[19:11]);
              check_eq("clear_start_y", start_y, cur[10:3]);
              check_eq("clear_colour", colour, cur[2:0]);
            end
          end
        end else if (clr_run != 0) begin
          check_eq("clear_len", clr_run, 1);
          clr_run = 0;
        end

        if (plot) begin
          plot_run++;
        end else if (plot_run != 0) begin
          check_eq("plot_len", plot_run, cur[34:22]);
          check_eq("job_done_at_finish", job_done, !cur[20]);
          check_eq("error_at_finish", error, cur[21]);
          check_eq("finish_start_y", start_y, cur[10:3]);
          check_eq("finish_colour", colour, cur[2:0]);
          check_eq("finish_enable_low", draw_enable, 0);
          if (job_done) done_seen++;
          plot_run = 0;
        end else if (job_done) begin
          check_eq("spurious_job_done", job_done, 0);
          done_seen++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int any_busy;
    int waited;
    reset         = 1'b1;
    rq.req_valid  = 1'b0;
    rq.req_slot   = '0;
    rq.req_colour = '0;
    rq.req_erase  = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    check_eq("rst_req_ready", rq.req_ready, 1);
    check_eq("rst_draw_resetn", draw_resetn, 1);
    check_eq("rst_draw_enable", draw_enable, 0);
    check_eq("rst_plot", plot, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_job_done", job_done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_start_x", start_x, X_ORIGIN);
    check_eq("rst_start_y", start_y, Y_ORIGIN);
    check_eq("rst_colour", colour, 0);
    check_eq("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    // single full-length job; popped on the cycle after acceptance
    push_req(2, 3'b110, 1'b0, FULL_LEN);
    check_eq("pop_latency_idle", busy, 0);
    @(posedge clk);
    #1;
    check_eq("pop_latency_busy", busy, 1);
    check_eq("pop_state_load", dbg_state, LOAD);
    wait_drain("single");
    check_eq("single_done_count", done_seen, 1);

    // erase draws in black
    push_req(0, 3'b111, 1'b1, 10);
    wait_drain("erase");
    check_eq("erase_held_colour", colour, 0);
    check_eq("erase_held_start_y", start_y, Y_ORIGIN);

    // fill the FIFO while the first job draws
    push_req(1, 1, 1'b0, 200);
    push_req(3, 2, 1'b0, 5);
    push_req(4, 3, 1'b0, 6);
    push_req(0, 4, 1'b0, 7);
    check_eq("fifo_three_ready", rq.req_ready, 1);
    push_req(2, 5, 1'b0, 8);
    check_eq("fifo_full_ready", rq.req_ready, 0);
    push_req(1, 7, 1'b1, 9);
    wait_drain("full");
    check_eq("full_done_count", done_seen, exp_done_total);

    // watchdog: drawer never finishes
    check_eq("wd_error_before", error, 0);
    push_req(1, 5, 1'b0, 0);
    wait_drain("watchdog");
    check_eq("wd_error_after", error, 1);
    check_eq("wd_busy_after", busy, 0);
    check_eq("wd_state_idle", dbg_state, IDLE);
    check_eq("wd_done_count", done_seen, exp_done_total);

    // asynchronous reset mid-DRAW with a second job queued
    push_req(3, 6, 1'b0, FULL_LEN);
    push_req(4, 1, 1'b0, 5);
    waited = 0;
    while (!plot && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("rst_mid_plot_started", plot, 1);
    repeat (99) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_plot", plot, 0);
    check_eq("rst_mid_enable", draw_enable, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_job_done", job_done, 0);
    check_eq("rst_mid_error", error, 0);
    check_eq("rst_mid_ready", rq.req_ready, 1);
    exp_q.delete();
    len_q.delete();
    err_acc = 1'b0;
    exp_done_total = done_seen;
    @(negedge clk);
    reset = 1'b0;
    any_busy = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy || job_done) any_busy++;
    end
    check_eq("rst_mid_fifo_empty", any_busy, 0);

    // invalid slot: error, no draw, outputs untouched, next job still runs
    push_req(6, 3, 1'b0, 5);
    wait_drain("invalid");
    check_eq("invalid_error", error, 1);
    check_eq("invalid_start_y_held", start_y, Y_ORIGIN);
    check_eq("invalid_colour_held", colour, 0);
    check_eq("invalid_done_count", done_seen, exp_done_total);
    push_req(4, 2, 1'b0, 12);
    wait_drain("after_invalid");
    check_eq("after_invalid_start_y", start_y, 184);
    check_eq("after_invalid_done_count", done_seen, exp_done_total);

    // randomized mix, including invalid slots and back-to-back pushes
    for (int i = 0; i < 16; i++) begin
      push_req($urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
               $urandom_range(1, 40));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain("random");
    check_eq("final_done_count", done_seen, exp_done_total);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
